// File: rtl/sram_burst_ctrl.sv
// Burst initiator for a single-port synchronous SRAM: write bursts stream straight into the
// macro, read bursts are prefetched into a 2-entry FIFO and drained with valid/ready backpressure.
module sram_burst_ctrl #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_write,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [AW-1:0] i_cmd_len,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic [DW-1:0] o_rd_data,
  output logic          o_busy,
  output logic          o_sram_write_en,
  output logic [AW-1:0] o_sram_address,
  output logic [DW-1:0] o_sram_data_in,
  input  logic [DW-1:0] i_sram_data_out,
  output logic [1:0]    o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and ready is a function of state and FIFO occupancy only.

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  localparam bit LAT1 = (RD_LAT != 0);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_cnt;
  logic          r_sram_we;
  logic [AW-1:0] r_sram_addr;
  logic [DW-1:0] r_sram_din;
  logic [DW-1:0] r_mem [0:1];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_occ;
  logic          r_v0;
  logic          r_v1;

  logic          w_cmd_fire;
  logic          w_wr_fire;
  logic          w_last;
  logic          w_pop;
  logic          w_push;
  logic [1:0]    w_inflight;
  logic [1:0]    w_total;
  logic          w_issue;
  logic [1:0]    w_occ_nxt;

  assign w_cmd_fire = i_cmd_valid && (r_state == S_IDLE);
  assign w_wr_fire  = i_wr_valid && (r_state == S_WRITE);
  assign w_last     = (r_cnt == '0);
  assign w_pop      = (r_occ != 2'd0) && i_rd_ready;
  // r_v0 marks the cycle the address is on the bus, r_v1 the cycle after it.
  assign w_push     = LAT1 ? r_v1 : r_v0;
  assign w_inflight = {1'b0, r_v0} + {1'b0, LAT1 && r_v1};
  assign w_total    = r_occ + w_inflight;
  assign w_issue    = (r_state == S_READ) && ((w_total - {1'b0, w_pop}) < 2'd2);
  assign w_occ_nxt  = r_occ + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_fire) w_next = i_cmd_write ? S_WRITE : S_READ;
      S_WRITE: if (w_wr_fire && w_last) w_next = S_IDLE;
      S_READ:  if (w_issue && w_last) w_next = S_DRAIN;
      S_DRAIN: if ((r_occ == 2'd0) && (w_inflight == 2'd0)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_sram_we   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
    end else begin
      r_sram_we <= w_wr_fire;
      r_v0      <= w_issue;
      r_v1      <= r_v0;
      if (w_cmd_fire) begin
        r_addr <= i_cmd_addr;
        r_cnt  <= i_cmd_len;
      end else if (w_wr_fire || w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_cnt       <= r_cnt - 1'b1;
        r_sram_addr <= r_addr;
      end
      if (w_wr_fire) r_sram_din <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_sram_data_out;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_occ <= w_occ_nxt;
    end
  end

  assign o_cmd_ready     = (r_state == S_IDLE);
  assign o_wr_ready      = (r_state == S_WRITE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_rd_valid      = (r_occ != 2'd0);
  assign o_rd_data       = r_mem[r_rp];
  assign o_sram_write_en = r_sram_we;
  assign o_sram_address  = r_sram_addr;
  assign o_sram_data_in  = r_sram_din;
  assign o_dbg_state     = r_state;

endmodule
